// File: rtl/dmem_master.sv
// Data-memory master for the MEM stage: one RAM access per request through an
// IDLE/ACCESS/RESP FSM, with big-endian byte lanes, load extension and alignment traps.
module dmem_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        excp_o,
  output logic        stall_req_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  localparam logic [1:0] SZ_B    = 2'd0;
  localparam logic [1:0] SZ_H    = 2'd1;
  localparam logic [1:0] SZ_W    = 2'd2;
  localparam logic [1:0] SZ_NONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Handshake: a request is taken on a rising edge where req_i & ready_o & ~flush_i;
  // op/addr/wdata are captured on that edge and the result is presented while done_o=1.
  state_t state_q;
  state_t state_d;

  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SZ_B;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_H;
      OP_LW, OP_SW:         op_size = SZ_W;
      default:              op_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    misaligned = ((size == SZ_H) && lo[0]) || ((size == SZ_W) && (lo != 2'b00));
  endfunction

  logic [1:0] in_size;
  logic       in_excp;
  logic       in_skip;
  logic       accept;

  assign in_size = op_size(op_i);
  assign in_excp = misaligned(in_size, addr_i[1:0]);
  // NOPs and misaligned requests bypass the RAM and answer straight from IDLE.
  assign in_skip = (in_size == SZ_NONE) || in_excp;
  assign accept  = req_i && ready_o && !flush_i;

  logic [1:0] q_size;
  logic       q_store;

  assign q_size  = op_size(op_q);
  assign q_store = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);

  logic [3:0]  lane_sel;
  logic [31:0] store_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_result;

  always_comb begin
    lane_sel   = 4'b0000;
    store_data = 32'd0;
    case (q_size)
      SZ_B: begin
        lane_sel   = 4'b1000 >> addr_q[1:0];
        store_data = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        lane_sel   = addr_q[1] ? 4'b0011 : 4'b1100;
        store_data = {2{wdata_q[15:0]}};
      end
      SZ_W: begin
        lane_sel   = 4'b1111;
        store_data = wdata_q;
      end
      default: begin
        lane_sel   = 4'b0000;
        store_data = 32'd0;
      end
    endcase
  end

  // Lane 0 (address offset 0) is the most significant byte of the RAM word.
  always_comb begin
    load_byte = 8'd0;
    case (addr_q[1:0])
      2'd0:    load_byte = mem_data_i[31:24];
      2'd1:    load_byte = mem_data_i[23:16];
      2'd2:    load_byte = mem_data_i[15:8];
      default: load_byte = mem_data_i[7:0];
    endcase
    load_half = addr_q[1] ? mem_data_i[15:0] : mem_data_i[31:16];
    case (op_q)
      OP_LB:   load_result = {{24{load_byte[7]}}, load_byte};
      OP_LBU:  load_result = {24'd0, load_byte};
      OP_LH:   load_result = {{16{load_half[15]}}, load_half};
      OP_LHU:  load_result = {16'd0, load_half};
      OP_LW:   load_result = mem_data_i;
      default: load_result = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = in_skip ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: state_d = flush_i ? S_IDLE : S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o     = (state_q == S_IDLE);
    done_o      = (state_q == S_RESP) && !flush_i;
    stall_req_o = (req_i && !ready_o) || accept;
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_sel_o   = 4'b0000;
    mem_data_o  = 32'd0;
    if (state_q == S_ACCESS) begin
      mem_ce_o   = 1'b1;
      mem_we_o   = q_store;
      mem_addr_o = {addr_q[31:2], 2'b00};
      mem_sel_o  = lane_sel;
      mem_data_o = q_store ? store_data : 32'd0;
    end
  end

  // Results change only on entry to RESP; a flushed ACCESS leaves the old result in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_o <= 32'd0;
      excp_o  <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        if (in_skip) begin
          rdata_o <= 32'd0;
          excp_o  <= in_excp;
        end
      end
      if ((state_q == S_ACCESS) && !flush_i) begin
        rdata_o <= q_store ? 32'd0 : load_result;
        excp_o  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dmem_master.md
DMEM_MASTER -- requirements
Module: dmem_master

Interface
REQ-001 The block SHALL have these ports; clock and reset come first, and the bus-facing group drives a byte-lane data RAM (ce/we/addr/sel/data, combinational read, posedge write):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i  in  1  request strobe from the MEM stage.
- op_i  in  4  access type: 0=LB, 1=LBU, 2=LH, 3=LHU, 4=LW, 8=SB, 9=SH, 10=SW; any other value is a NOP.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-aligned.
- flush_i  in  1  pipeline flush.
- ready_o  out  1  block is idle and can accept a request.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  extended load result.
- excp_o  out  1  misaligned-address exception; valid with done_o.
- stall_req_o  out  1  pipeline stall request.
- mem_ce_o  out  1  RAM chip enable.
- mem_we_o  out  1  RAM write enable.
- mem_addr_o  out  32  RAM address.
- mem_sel_o  out  4  RAM byte-lane select.
- mem_data_o  out  32  RAM write data.
- mem_data_i  in  32  RAM read data.

Function
REQ-002 The block SHALL implement a three-state FSM:
- IDLE -> ACCESS on an accepted aligned non-NOP request.
- IDLE -> RESP on an accepted misaligned or NOP request.
- ACCESS -> RESP.
- RESP -> IDLE.
REQ-003 A request SHALL be accepted only when req_i=1, ready_o=1 and flush_i=0; op, addr and wdata are latched at that edge.
REQ-004 ready_o SHALL be 1 only in IDLE; stall_req_o SHALL equal req_i & ~ready_o, plus 1 in the IDLE cycle where a request is accepted.
REQ-005 Alignment SHALL be checked as follows; a failing request sets excp_o, generates no RAM access, and returns rdata_o=0:
- LH/LHU/SH require addr[0]=0.
- LW/SW require addr[1:0]=0.
REQ-006 In ACCESS, mem_ce_o SHALL be 1; in all other states mem_ce_o, mem_we_o, mem_sel_o and mem_data_o SHALL be 0.
REQ-007 In ACCESS, mem_addr_o SHALL be {addr[31:2],2'b00}; mem_we_o SHALL be 1 for stores and 0 for loads.
REQ-008 Byte lanes SHALL be big-endian:
- Byte ops: addr[1:0] 0/1/2/3 -> sel 1000/0100/0010/0001.
- Half ops: addr[1]=0 -> 1100, addr[1]=1 -> 0011.
- Word ops: 1111.
REQ-009 Store data SHALL be replicated across lanes: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-010 For loads, mem_data_i SHALL be sampled at the ACCESS->RESP edge:
- The selected byte/half is extracted per REQ-008.
- It is sign-extended for LB/LH and zero-extended for LBU/LHU; LW is taken unmodified.
- The result is registered into rdata_o.
REQ-011 done_o SHALL be 1 exactly in RESP, with rdata_o and excp_o valid in that cycle; for stores and NOPs, rdata_o SHALL be 0.
REQ-012 Latency SHALL be: accept at edge N, ACCESS in cycle N+1, done_o in cycle N+2; exception and NOP requests see done_o in cycle N+1.
REQ-013 rdata_o and excp_o SHALL hold their values until the next RESP or reset.
REQ-014 flush_i handling:
- flush_i=1 in ACCESS: the RAM cycle still completes; the next state is IDLE and done_o is not asserted.
- flush_i=1 in RESP: done_o is forced to 0 and the next state is IDLE.
REQ-015 req_i outside IDLE SHALL be ignored; it is not queued.
REQ-016 A back-to-back request SHALL be acceptable in the IDLE cycle immediately following RESP; maximum throughput is one access per 3 cycles.

Reset
REQ-017 While rst=1 at a rising edge, the state SHALL become IDLE, with:
- rdata_o=0, excp_o=0, done_o=0, ready_o=1 (from the following cycle).
- Latched op/addr/wdata cleared to 0.
REQ-018 Reset SHALL take priority over req_i and flush_i.
REQ-019 Mid-operation reset behaviour:
- A store whose ACCESS cycle coincides with rst=1 SHALL still be written by the RAM at that edge.
- A load in the same situation is discarded.
REQ-020 After reset, no RAM strobe SHALL be driven until a new request is accepted.

Verification
REQ-021 SW addr=0x100 data=0xA1B2C3D4, then LW 0x100 -> ACCESS shows sel=1111 we=1; the load's done_o comes 2 cycles after accept with rdata_o=0xA1B2C3D4.
REQ-022 SB addr=0x103 data=0x80, then LB 0x103 and LBU 0x103 -> store sel=0001 mem_data_o=0x80808080; rdata_o=0xFFFFFF80 then 0x00000080.
REQ-023 LH addr=0x102 over word 0x12348765 -> sel=0011 rdata_o=0xFFFF8765; LHU gives 0x00008765.
REQ-024 LW addr=0x101 and SH addr=0x203 -> mem_ce_o stays 0; done_o one cycle after accept with excp_o=1, rdata_o=0; memory contents are unchanged.
REQ-025 Flush and reset:
- flush_i pulsed during ACCESS of SW 0x300 -> word written, no done_o, ready_o=1 next cycle.
- rst asserted during ACCESS of SW 0x304 -> word written, outputs at reset values.
REQ-026 req_i held high continuously with alternating LW/SW ops -> accepts occur exactly every 3 cycles; stall_req_o is 1 while busy; no request is lost or duplicated.
